// File: rtl/spi_fifo_pkg.sv
// Shared constants for the SPI FIFO bridge: default depth, ERR bit map and
// FIFO_EN request bit map.
package spi_fifo_pkg;

  localparam int DEPTH_DEF = 8;

  // ERR vector bit positions
  localparam int ERR_TXOVF = 0;
  localparam int ERR_TXUDR = 1;
  localparam int ERR_RXOVR = 2;
  localparam int ERR_W     = 3;

  // FIFO_EN request bit positions
  localparam int FEN_TX = 0;
  localparam int FEN_RX = 1;
  localparam int FEN_W  = 2;

endpackage

// File: rtl/spi_sync_fifo.sv
// Single-clock byte FIFO with show-ahead head, separate level counter and
// flush. Storage is not reset; pointers and level are.
module spi_sync_fifo #(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          flush_i,
  input  logic [7:0]    wdata_i,
  output logic [7:0]    rdata_o,
  output logic [AW:0]   level_o,
  output logic          full_o,
  output logic          empty_o,
  output logic          push_ok_o,
  output logic          pop_ok_o
);

  logic [7:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   level_q, level_d;

  assign full_o  = (level_q == (AW+1)'(DEPTH));
  assign empty_o = (level_q == '0);
  assign rdata_o = mem_q[rptr_q];
  assign level_o = level_q;

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign pop_ok_o  = pop_i & ~flush_i & ~empty_o;
  assign push_ok_o = push_i & ~flush_i & (~full_o | pop_ok_o);

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      level_d = '0;
    end else begin
      if (push_ok_o) wptr_d = wptr_q + AW'(1);
      if (pop_ok_o)  rptr_d = rptr_q + AW'(1);
      case ({push_ok_o, pop_ok_o})
        2'b10:   level_d = level_q + (AW+1)'(1);
        2'b01:   level_d = level_q - (AW+1)'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok_o) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/spi_fifo_bridge.sv
// TX/RX byte FIFOs between the APB register file and the SPI core.
// Define SPI_FIFO_IRQ_EN to build the level/error threshold interrupt.
module spi_fifo_bridge
  import spi_fifo_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              TX_WR,
  input  logic [7:0]        TX_WDATA,
  input  logic              RX_RD,
  output logic [7:0]        RX_RDATA,
  input  logic              TX_FLUSH,
  input  logic              RX_FLUSH,
  input  logic [ERR_W-1:0]  ERR_CLR,
  input  logic [FEN_W-1:0]  FIFO_EN,
  input  logic [7:0]        RX_REG,
  output logic [7:0]        DATA_SHIFT_REG,
  output logic              SEL_DATA,
  output logic [AW:0]       TX_LEVEL,
  output logic [AW:0]       RX_LEVEL,
  output logic              TX_FULL,
  output logic              TX_EMPTY,
  output logic              RX_FULL,
  output logic              RX_EMPTY,
  output logic [ERR_W-1:0]  ERR,
  input  logic [AW:0]       TX_THRESH,
  input  logic [AW:0]       RX_THRESH,
  output logic              FIFO_IRQ
);

  // Two-deep sampling of FIFO_EN; a request is a 0->1 step between stages.
  logic [FEN_W-1:0] fen_s1_q, fen_s2_q, fen_rise;
  logic             tx_push_ok, tx_pop_ok, rx_push_ok, rx_pop_ok;
  logic [7:0]       tx_head;
  logic [7:0]       data_shift_q, data_shift_d;
  logic             sel_q;
  logic [ERR_W-1:0] err_q, err_d, err_set;

  assign fen_rise = fen_s1_q & ~fen_s2_q;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      fen_s1_q <= '0;
      fen_s2_q <= '0;
    end else begin
      fen_s1_q <= FIFO_EN;
      fen_s2_q <= fen_s1_q;
    end
  end

  spi_sync_fifo #(.DEPTH(DEPTH), .AW(AW)) u_tx_fifo (
    .clk       (PCLK),
    .rst_n     (PRESETn),
    .push_i    (TX_WR),
    .pop_i     (fen_rise[FEN_TX]),
    .flush_i   (TX_FLUSH),
    .wdata_i   (TX_WDATA),
    .rdata_o   (tx_head),
    .level_o   (TX_LEVEL),
    .full_o    (TX_FULL),
    .empty_o   (TX_EMPTY),
    .push_ok_o (tx_push_ok),
    .pop_ok_o  (tx_pop_ok)
  );

  // RX_REG is written in the edge-detect cycle, one cycle after sampling.
  spi_sync_fifo #(.DEPTH(DEPTH), .AW(AW)) u_rx_fifo (
    .clk       (PCLK),
    .rst_n     (PRESETn),
    .push_i    (fen_rise[FEN_RX]),
    .pop_i     (RX_RD),
    .flush_i   (RX_FLUSH),
    .wdata_i   (RX_REG),
    .rdata_o   (RX_RDATA),
    .level_o   (RX_LEVEL),
    .full_o    (RX_FULL),
    .empty_o   (RX_EMPTY),
    .push_ok_o (rx_push_ok),
    .pop_ok_o  (rx_pop_ok)
  );

  // Dropped pushes under flush are a flush, not an overflow.
  always_comb begin
    err_set            = '0;
    err_set[ERR_TXOVF] = TX_WR & ~tx_push_ok & ~TX_FLUSH;
    err_set[ERR_TXUDR] = fen_rise[FEN_TX] & TX_EMPTY;
    err_set[ERR_RXOVR] = fen_rise[FEN_RX] & ~rx_push_ok & ~RX_FLUSH;
    err_d              = (err_q & ~ERR_CLR) | err_set;
    data_shift_d       = tx_pop_ok ? tx_head : data_shift_q;
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      data_shift_q <= '0;
      sel_q        <= 1'b0;
      err_q        <= '0;
    end else begin
      data_shift_q <= data_shift_d;
      sel_q        <= tx_pop_ok;
      err_q        <= err_d;
    end
  end

  assign DATA_SHIFT_REG = data_shift_q;
  assign SEL_DATA       = sel_q;
  assign ERR            = err_q;

`ifdef SPI_FIFO_IRQ_EN
  logic irq_q, irq_d;

  assign irq_d = (TX_LEVEL <= TX_THRESH) | (RX_LEVEL >= RX_THRESH) | (|err_q);

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) irq_q <= 1'b0;
    else          irq_q <= irq_d;
  end

  assign FIFO_IRQ = irq_q;
`else
  logic unused_thresh;
  assign unused_thresh = ^{TX_THRESH, RX_THRESH, rx_pop_ok};
  assign FIFO_IRQ      = 1'b0;
`endif

endmodule

// File: tb/tb_spi_fifo_bridge.sv
// Directed and randomized checks of spi_fifo_bridge against a queue model.
module tb_spi_fifo_bridge;

  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic             PCLK = 1'b0;
  logic             PRESETn;
  logic             TX_WR, RX_RD, TX_FLUSH, RX_FLUSH;
  logic [7:0]       TX_WDATA, RX_REG, RX_RDATA, DATA_SHIFT_REG;
  logic [2:0]       ERR_CLR, ERR;
  logic [1:0]       FIFO_EN;
  logic             SEL_DATA, TX_FULL, TX_EMPTY, RX_FULL, RX_EMPTY, FIFO_IRQ;
  logic [AW:0]      TX_LEVEL, RX_LEVEL, TX_THRESH, RX_THRESH;

  int n_chk = 0;
  int n_err = 0;

  spi_fifo_bridge #(.DEPTH(DEPTH)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .TX_WR(TX_WR), .TX_WDATA(TX_WDATA),
    .RX_RD(RX_RD), .RX_RDATA(RX_RDATA), .TX_FLUSH(TX_FLUSH), .RX_FLUSH(RX_FLUSH),
    .ERR_CLR(ERR_CLR), .FIFO_EN(FIFO_EN), .RX_REG(RX_REG),
    .DATA_SHIFT_REG(DATA_SHIFT_REG), .SEL_DATA(SEL_DATA),
    .TX_LEVEL(TX_LEVEL), .RX_LEVEL(RX_LEVEL), .TX_FULL(TX_FULL),
    .TX_EMPTY(TX_EMPTY), .RX_FULL(RX_FULL), .RX_EMPTY(RX_EMPTY), .ERR(ERR),
    .TX_THRESH(TX_THRESH), .RX_THRESH(RX_THRESH), .FIFO_IRQ(FIFO_IRQ)
  );

  always #5 PCLK = ~PCLK;

  task automatic cyc();
    @(posedge PCLK); #1;
  endtask

  task automatic tx_write(input logic [7:0] b);
    TX_WR = 1'b1; TX_WDATA = b; cyc(); TX_WR = 1'b0;
  endtask

  task automatic tx_pulse(output logic sel, output logic [7:0] d);
    FIFO_EN[0] = 1'b1; cyc(); FIFO_EN[0] = 1'b0; cyc();
    sel = SEL_DATA; d = DATA_SHIFT_REG; cyc();
  endtask

  task automatic rx_push(input logic [7:0] b);
    FIFO_EN[1] = 1'b1; RX_REG = b; cyc(); FIFO_EN[1] = 1'b0; cyc(); cyc();
  endtask

  task automatic rx_pop(output logic [7:0] d);
    d = RX_RDATA; RX_RD = 1'b1; cyc(); RX_RD = 1'b0;
  endtask

  task automatic clr_err(input logic [2:0] m);
    ERR_CLR = m; cyc(); ERR_CLR = 3'b000;
  endtask

  task automatic flush_both();
    TX_FLUSH = 1'b1; RX_FLUSH = 1'b1; cyc(); TX_FLUSH = 1'b0; RX_FLUSH = 1'b0;
  endtask

  task automatic test_reset();
    PRESETn = 1'b0; TX_WR = 0; RX_RD = 0; TX_FLUSH = 0; RX_FLUSH = 0;
    ERR_CLR = 0; FIFO_EN = 0; RX_REG = 0; TX_WDATA = 0;
    TX_THRESH = 4'd1; RX_THRESH = 4'd8;
    #3;
    n_chk++;
    if ({DATA_SHIFT_REG, SEL_DATA, TX_LEVEL, RX_LEVEL, ERR, FIFO_IRQ} !== 23'd0 ||
        {TX_EMPTY, RX_EMPTY, TX_FULL, RX_FULL} !== 4'b1100) begin
      n_err++;
      $display("FAIL reset: dsr=%h sel=%b txl=%0d rxl=%0d err=%b irq=%b flags=%b%b%b%b",
               DATA_SHIFT_REG, SEL_DATA, TX_LEVEL, RX_LEVEL, ERR, FIFO_IRQ,
               TX_EMPTY, RX_EMPTY, TX_FULL, RX_FULL);
    end
    cyc(); PRESETn = 1'b1; cyc();
  endtask

  task automatic test_tx_basic();
    logic sel; logic [7:0] d;
    tx_write(8'hA5); tx_write(8'h3C);
    n_chk++;
    if (TX_LEVEL !== 4'd2) begin n_err++; $display("FAIL tx_level2: got %0d want 2", TX_LEVEL); end
    FIFO_EN[0] = 1'b1; cyc(); FIFO_EN[0] = 1'b0;
    n_chk++;
    if (SEL_DATA !== 1'b0) begin n_err++; $display("FAIL sel_early: got %b want 0", SEL_DATA); end
    cyc();
    n_chk++;
    if (SEL_DATA !== 1'b1 || DATA_SHIFT_REG !== 8'hA5) begin
      n_err++; $display("FAIL pop1: sel=%b dsr=%h want 1/a5", SEL_DATA, DATA_SHIFT_REG);
    end
    cyc();
    n_chk++;
    if (SEL_DATA !== 1'b0) begin n_err++; $display("FAIL sel_one_cycle: got %b want 0", SEL_DATA); end
    tx_pulse(sel, d);
    n_chk++;
    if (sel !== 1'b1 || d !== 8'h3C || TX_EMPTY !== 1'b1) begin
      n_err++; $display("FAIL pop2: sel=%b dsr=%h empty=%b want 1/3c/1", sel, d, TX_EMPTY);
    end
  endtask

  task automatic test_hold();
    int cnt = 0;
    flush_both();
    tx_write(8'h51); tx_write(8'h52); tx_write(8'h53);
    FIFO_EN[0] = 1'b1;
    repeat (20) begin cyc(); if (SEL_DATA === 1'b1) cnt++; end
    FIFO_EN[0] = 1'b0; cyc(); cyc();
    n_chk++;
    if (cnt != 1 || TX_LEVEL !== 4'd2) begin
      n_err++; $display("FAIL hold: pops=%0d level=%0d want 1/2", cnt, TX_LEVEL);
    end
  endtask

  task automatic test_overflow();
    logic sel; logic [7:0] d;
    flush_both(); clr_err(3'b111);
    for (int i = 0; i < 9; i++) tx_write(8'h10 + 8'(i));
    n_chk++;
    if (TX_LEVEL !== 4'd8 || ERR[0] !== 1'b1 || TX_FULL !== 1'b1) begin
      n_err++; $display("FAIL overflow: level=%0d err=%b full=%b want 8/xx1/1", TX_LEVEL, ERR, TX_FULL);
    end
    for (int i = 0; i < 8; i++) begin
      tx_pulse(sel, d);
      n_chk++;
      if (sel !== 1'b1 || d !== 8'h10 + 8'(i)) begin
        n_err++; $display("FAIL ovf_seq%0d: sel=%b dsr=%h want 1/%h", i, sel, d, 8'h10 + 8'(i));
      end
    end
    clr_err(3'b001);
    n_chk++;
    if (ERR !== 3'b000 || TX_EMPTY !== 1'b1) begin
      n_err++; $display("FAIL ovf_clear: err=%b empty=%b want 000/1", ERR, TX_EMPTY);
    end
  endtask

  task automatic test_rx_full();
    logic [7:0] d;
    logic [7:0] exp_q[$];
    flush_both(); clr_err(3'b111);
    for (int i = 0; i < 8; i++) begin rx_push(8'h20 + 8'(i)); exp_q.push_back(8'h20 + 8'(i)); end
    n_chk++;
    if (RX_LEVEL !== 4'd8 || RX_FULL !== 1'b1) begin
      n_err++; $display("FAIL rx_fill: level=%0d full=%b want 8/1", RX_LEVEL, RX_FULL);
    end
    FIFO_EN[1] = 1'b1; RX_REG = 8'h99; cyc();
    FIFO_EN[1] = 1'b0; RX_RD = 1'b1; cyc(); RX_RD = 1'b0;
    void'(exp_q.pop_front()); exp_q.push_back(8'h99);
    cyc();
    n_chk++;
    if (RX_LEVEL !== 4'd8 || ERR[2] !== 1'b0) begin
      n_err++; $display("FAIL rx_full_pushpop: level=%0d err=%b want 8/0xx", RX_LEVEL, ERR);
    end
    rx_push(8'h77);
    n_chk++;
    if (RX_LEVEL !== 4'd8 || ERR[2] !== 1'b1) begin
      n_err++; $display("FAIL rx_overrun: level=%0d err=%b want 8/1xx", RX_LEVEL, ERR);
    end
    for (int i = 0; i < 8; i++) begin
      rx_pop(d);
      n_chk++;
      if (d !== exp_q[i]) begin n_err++; $display("FAIL rx_seq%0d: got %h want %h", i, d, exp_q[i]); end
    end
    RX_RD = 1'b1; cyc(); RX_RD = 1'b0;
    n_chk++;
    if (RX_LEVEL !== 4'd0 || RX_EMPTY !== 1'b1 || ERR !== 3'b100) begin
      n_err++; $display("FAIL rx_empty_rd: level=%0d empty=%b err=%b want 0/1/100", RX_LEVEL, RX_EMPTY, ERR);
    end
  endtask

  task automatic test_underrun();
    clr_err(3'b111); TX_FLUSH = 1'b1; cyc(); TX_FLUSH = 1'b0;
    FIFO_EN[0] = 1'b1; cyc(); FIFO_EN[0] = 1'b0; cyc();
    n_chk++;
    if (SEL_DATA !== 1'b0 || DATA_SHIFT_REG !== 8'h17 || ERR !== 3'b010) begin
      n_err++; $display("FAIL underrun: sel=%b dsr=%h err=%b want 0/17/010", SEL_DATA, DATA_SHIFT_REG, ERR);
    end
    cyc();
    n_chk++;
`ifdef SPI_FIFO_IRQ_EN
    if (FIFO_IRQ !== 1'b1) begin n_err++; $display("FAIL irq: got %b want 1", FIFO_IRQ); end
`else
    if (FIFO_IRQ !== 1'b0) begin n_err++; $display("FAIL irq: got %b want 0", FIFO_IRQ); end
`endif
  endtask

  task automatic test_flush();
    clr_err(3'b111);
    for (int i = 0; i < 5; i++) tx_write(8'h60 + 8'(i));
    TX_FLUSH = 1'b1; TX_WR = 1'b1; TX_WDATA = 8'hEE; cyc();
    TX_FLUSH = 1'b0; TX_WR = 1'b0;
    n_chk++;
    if (TX_LEVEL !== 4'd0 || TX_EMPTY !== 1'b1) begin
      n_err++; $display("FAIL flush: level=%0d empty=%b want 0/1", TX_LEVEL, TX_EMPTY);
    end
    FIFO_EN[0] = 1'b1; cyc(); FIFO_EN[0] = 1'b0; cyc();
    n_chk++;
    if (SEL_DATA !== 1'b0 || ERR !== 3'b010 || DATA_SHIFT_REG !== 8'h17) begin
      n_err++; $display("FAIL flush_udr: sel=%b err=%b dsr=%h want 0/010/17", SEL_DATA, ERR, DATA_SHIFT_REG);
    end
    cyc();
  endtask

  // Model: a FIFO_EN rise driven in cycle t is one request acting in cycle
  // t+1 together with that cycle's APB strobes and RX_REG.
  task automatic test_random();
    logic [7:0] txq[$], rxq[$];
    logic [2:0] m_err = 3'b000, set;
    logic [7:0] m_dsr = 8'h00, head;
    logic       m_sel;
    logic [1:0] prev_en = 2'b00, pend = 2'b00;
    bit         tx_pop, rx_pop, bad;
    PRESETn = 1'b0; FIFO_EN = 0; cyc(); PRESETn = 1'b1; cyc();
    for (int it = 0; it < 400; it++) begin
      TX_WR    = ($urandom_range(0, 1) == 1);
      TX_WDATA = 8'($urandom);
      RX_RD    = ($urandom_range(0, 4) == 0);
      RX_REG   = 8'($urandom);
      ERR_CLR  = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'b000;
      FIFO_EN  = 2'($urandom);
      set = 3'b000; m_sel = 1'b0;
      tx_pop = pend[0] && txq.size() > 0;
      if (pend[0] && txq.size() == 0) set[1] = 1'b1;
      if (tx_pop) begin head = txq.pop_front(); m_dsr = head; m_sel = 1'b1; end
      if (TX_WR) begin
        if (txq.size() < DEPTH) txq.push_back(TX_WDATA);
        else set[0] = 1'b1;
      end
      rx_pop = RX_RD && rxq.size() > 0;
      if (rx_pop) void'(rxq.pop_front());
      if (pend[1]) begin
        if (rxq.size() < DEPTH) rxq.push_back(RX_REG);
        else set[2] = 1'b1;
      end
      m_err = (m_err & ~ERR_CLR) | set;
      pend = FIFO_EN & ~prev_en; prev_en = FIFO_EN;
      cyc();
      bad = (TX_LEVEL !== 4'(txq.size())) || (RX_LEVEL !== 4'(rxq.size())) ||
            (TX_FULL !== (txq.size() == DEPTH)) || (RX_EMPTY !== (rxq.size() == 0)) ||
            (SEL_DATA !== m_sel) || (DATA_SHIFT_REG !== m_dsr) || (ERR !== m_err) ||
            (rxq.size() > 0 && RX_RDATA !== rxq[0]);
      n_chk++;
      if (bad) begin
        n_err++;
        $display("FAIL rand%0d: txl=%0d/%0d rxl=%0d/%0d sel=%b/%b dsr=%h/%h err=%b/%b",
                 it, TX_LEVEL, txq.size(), RX_LEVEL, rxq.size(), SEL_DATA, m_sel,
                 DATA_SHIFT_REG, m_dsr, ERR, m_err);
      end
    end
    TX_WR = 0; RX_RD = 0; ERR_CLR = 0;
    #2 PRESETn = 1'b0; #1;
    n_chk++;
    if (TX_LEVEL !== 4'd0 || RX_LEVEL !== 4'd0 || ERR !== 3'b000 || SEL_DATA !== 1'b0) begin
      n_err++; $display("FAIL midreset: txl=%0d rxl=%0d err=%b sel=%b want 0/0/000/0",
                        TX_LEVEL, RX_LEVEL, ERR, SEL_DATA);
    end
    FIFO_EN = 0; cyc(); PRESETn = 1'b1; cyc();
  endtask

  initial begin
    test_reset();
    test_tx_basic();
    test_hold();
    test_overflow();
    test_rx_full();
    test_underrun();
    test_flush();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/spi_fifo_bridge.md
# spi_fifo_bridge

Buffering stage between the APB register file and the SPI core. Holds a TX FIFO that feeds the core's transmit byte and load strobe, and an RX FIFO that captures each received byte. It converts the core's FIFO_EN request bits into single-cycle push/pop operations and reports levels, sticky error flags and an optional threshold interrupt to the APB interface.

## Interface
- DEPTH, 8: entries per FIFO; power of two, ≥2.
- AW, $clog2(DEPTH): pointer width; derived, do not override.
- PCLK  in  1  clock.
- PRESETn  in  1  asynchronous, active-low reset.
- TX_WR  in  1  APB write strobe; pushes TX_WDATA.
- TX_WDATA  in  8  byte to transmit.
- RX_RD  in  1  APB read strobe; pops the RX head.
- RX_RDATA  out  8  RX head (show-ahead), combinational from storage.
- TX_FLUSH, RX_FLUSH  in  1 each  empty the respective FIFO.
- ERR_CLR  in  3  W1C for {RX_OVERRUN, TX_UNDERRUN, TX_OVERFLOW}.
- FIFO_EN  in  2  from core: [0] TX byte request, [1] RX byte ready.
- RX_REG  in  8  received byte from core.
- DATA_SHIFT_REG  out  8  byte presented to core.
- SEL_DATA  out  1  one-cycle load strobe to core.
- TX_LEVEL, RX_LEVEL  out  AW+1  occupancy.
- TX_FULL, TX_EMPTY, RX_FULL, RX_EMPTY  out  1  status.
- ERR  out  3  sticky {RX_OVERRUN, TX_UNDERRUN, TX_OVERFLOW}.
- TX_THRESH, RX_THRESH  in  AW+1  interrupt thresholds.
- FIFO_IRQ  out  1  threshold interrupt.

## Operation
- FIFO_EN bits are registered once per cycle. A rising edge of a bit is one request. A level held high is never a repeat request.
- TX pop: on a FIFO_EN[0] rising edge with TX not empty, register the head into DATA_SHIFT_REG, pulse SEL_DATA, advance the read pointer.
- TX underrun: on a FIFO_EN[0] rising edge with TX empty, SEL_DATA stays 0, DATA_SHIFT_REG holds its value, TX_UNDERRUN is set.
- TX push: TX_WR with not full stores the byte.
- TX overflow: TX_WR while full, with no same-cycle pop, drops the byte and sets TX_OVERFLOW.
- RX push: on a FIFO_EN[1] rising edge, store RX_REG.
- RX overrun: if RX is full with no same-cycle RX_RD, drop the byte and set RX_OVERRUN.
- RX pop: RX_RD pops the head. RX_RD while empty is ignored and sets no flag.
- Simultaneous push and pop on one FIFO: both take effect and the level is unchanged. This holds even when the FIFO is full.
- Flush: clears both pointers and the level of that FIFO. Flush beats a concurrent push/pop. Flush does not touch the error flags or DATA_SHIFT_REG.
- Error flags: set beats ERR_CLR in the same cycle.
- Pointers: AW bits, wrap modulo DEPTH. Level is tracked as a separate AW+1 counter. FULL = (level == DEPTH), EMPTY = (level == 0).

## Timing
- Reset values: DATA_SHIFT_REG=0, SEL_DATA=0, both levels 0, EMPTY=1, FULL=0, ERR=0, FIFO_IRQ=0. RX_RDATA reads storage, which is undefined after reset; storage is not reset.
- FIFO_EN edge → SEL_DATA and new DATA_SHIFT_REG: 2 PCLK cycles (1 sampling register + 1 output register).
- FIFO_EN[1] edge → RX_LEVEL increments: 2 cycles. RX_REG is captured in the edge-detect cycle, so the core must hold RX_REG stable ≥2 cycles after raising FIFO_EN[1].
- TX_WR/RX_RD → level and flags updated: next cycle. RX_RDATA changes in the cycle after RX_RD.
- Reset mid-operation: all state returns to reset values immediately (asynchronous). Any in-flight request is lost.

## Configuration
- SPI_FIFO_IRQ_EN defined: FIFO_IRQ is registered as (TX_LEVEL ≤ TX_THRESH) | (RX_LEVEL ≥ RX_THRESH) | (|ERR), updated 1 cycle after any level or flag change.
- SPI_FIFO_IRQ_EN undefined: FIFO_IRQ is tied 0, the threshold inputs are unused, and no compare logic is generated.

## Structure
- Package spi_fifo_pkg:
  - default DEPTH;
  - ERR bit indices ERR_TXOVF=0, ERR_TXUDR=1, ERR_RXOVR=2;
  - FIFO_EN bit indices.
- Sub-module spi_sync_fifo holds storage, pointers and the level counter, with push/pop/flush/full/empty. It is instantiated twice (TX, RX).
- Edge detection, the SEL_DATA strobe, error flags and the IRQ live in the top.

## Test plan
- Reset, write 0xA5, 0x3C; pulse FIFO_EN[0] twice → SEL_DATA pulses with DATA_SHIFT_REG=0xA5 then 0x3C, each 2 cycles after its edge; TX_EMPTY=1 at the end.
- FIFO_EN[0] held high 20 cycles with 3 bytes queued → exactly one pop; TX_LEVEL 3→2.
- 9 TX_WR with DEPTH=8 → TX_LEVEL=8, ERR[0]=1, 9th byte absent from the pop sequence. Then ERR_CLR=3'b001 → ERR[0]=0.
- RX full (8 entries); FIFO_EN[1] edge and RX_RD in the same cycle → level stays 8, no overrun, new byte is last in order. A further edge without RX_RD → ERR[2]=1.
- FIFO_EN[0] edge on empty TX → no SEL_DATA, ERR[1]=1. With the IRQ macro defined, FIFO_IRQ=1 one cycle later.
- TX_FLUSH concurrent with TX_WR at level 5 → level 0; the next pop request underruns.
